// File: rtl/pipeline_fetch_ctrl.sv
// pipeline_fetch_ctrl: fetch sequencer with one outstanding imem request, decode-hazard hold and squashing redirects
module pipeline_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard,
  input  logic        pcsrc,
  input  logic [31:0] branchaddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);
  typedef enum logic [1:0] {FETCH, WAIT, OUT} state_t;
  state_t      state;
  logic [31:0] fpc;
  logic        squash;
  assign imem_req    = (state == FETCH) & ~reset;
  assign imem_addr   = fpc;
  assign instr_valid = (state == OUT);
  assign pcplus4     = pc + 32'd4;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      fpc    <= RESET_PC;
      squash <= 1'b0;
      instr  <= 32'd0;
      pc     <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (pcsrc) fpc <= branchaddr;
          if (imem_gnt) begin
            state  <= WAIT;
            squash <= pcsrc;
          end
        end
        WAIT: begin
          // squash marks data already owed to a request that a redirect made stale
          if (imem_rvalid) begin
            if (squash | pcsrc) begin
              state  <= FETCH;
              squash <= 1'b0;
              if (pcsrc) fpc <= branchaddr;
            end else begin
              instr <= imem_rdata;
              pc    <= fpc;
              fpc   <= fpc + 32'd4;
              state <= OUT;
            end
          end else if (pcsrc) begin
            fpc    <= branchaddr;
            squash <= 1'b1;
          end
        end
        OUT: begin
          if (pcsrc) begin
            fpc   <= branchaddr;
            state <= FETCH;
          end else if (!hazard) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
